spi_master: RTL and testbench

- Single-clock SPI initiator. Drives sclk, ss and mosi toward the team's SPI slave, and captures miso from it.
- Each transfer is one full-duplex word, MSB first. ss is active-high to match our slave.
- sclk idles low. The master changes mosi on sclk falling edges; the slave samples mosi on rising edges. The slave updates miso on rising edges; the master samples miso on falling edges.
- Sits between a local controller (start/done handshake) and the off-block SPI pins.

---
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_master.sv | 159 +++++++++++++++
 tb/tb_spi_master.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Bundles the controller handshake and the SPI pins of spi_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  sclk;
  logic                  ss;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, data_in, miso,
    output busy, done, data_out, sclk, ss, mosi
  );

  modport slave (
    output start, data_in, miso,
    input  busy, done, data_out, sclk, ss, mosi
  );
endinterface

// File: rtl/spi_master.sv
// Single-clock SPI initiator: one full-duplex MSB-first word per start, mode-0 style
// timing (sclk idles low, mosi changes and miso is sampled on sclk falling edges).
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_e;

  state_e                state_q,    state_d;
  logic [DIV_W-1:0]      div_q,      div_d;
  logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q,       tx_d;
  logic [DATA_WIDTH-1:0] rx_q,       rx_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  sclk_q,     sclk_d;
  logic                  ss_q,       ss_d;
  logic                  mosi_q,     mosi_d;
  logic                  div_end_s;

  assign div_end_s = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d      = bus.data_in;
          rx_d      = {DATA_WIDTH{1'b0}};
          bit_cnt_d = {CNT_W{1'b0}};
          div_d     = {DIV_W{1'b0}};
          ss_d      = 1'b1;
          busy_d    = 1'b1;
          mosi_d    = bus.data_in[DATA_WIDTH-1];
          state_d   = SETUP;
        end else begin
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      SETUP, LOW: begin
        if (div_end_s) begin
          div_d   = {DIV_W{1'b0}};
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HIGH: begin
        if (div_end_s) begin
          div_d     = {DIV_W{1'b0}};
          sclk_d    = 1'b0;
          rx_d      = {rx_q[DATA_WIDTH-2:0], bus.miso};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = HOLD;
          end else begin
            // Rotate so tx_q[DATA_WIDTH-2] is always the next bit to present.
            mosi_d  = tx_q[DATA_WIDTH-2];
            tx_d    = {tx_q[DATA_WIDTH-2:0], tx_q[DATA_WIDTH-1]};
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_end_s) begin
          div_d      = {DIV_W{1'b0}};
          ss_d       = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mosi_d     = 1'b0;
          data_out_d = rx_q;
          state_d    = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        div_d   = {DIV_W{1'b0}};
        sclk_d  = 1'b0;
        ss_d    = 1'b0;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces every pin to its idle value at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= {DIV_W{1'b0}};
      bit_cnt_q  <= {CNT_W{1'b0}};
      tx_q       <= {DATA_WIDTH{1'b0}};
      rx_q       <= {DATA_WIDTH{1'b0}};
      data_out_q <= {DATA_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;
  assign bus.sclk     = sclk_q;
  assign bus.ss       = ss_q;
  assign bus.mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a default 8-bit/CLK_DIV=2 instance with a loopback
// or behavioural slave on miso, plus a 16-bit/CLK_DIV=4 instance with constant miso.
module tb_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  spi_master_if #(.DATA_WIDTH(8))  bus ();
  spi_master_if #(.DATA_WIDTH(16)) bus_w ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  spi_master #(.DATA_WIDTH(16), .CLK_DIV(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w)
  );

  bit   loopback = 1'b1;
  logic slave_miso = 1'b0;
  logic miso_w = 1'b0;
  assign bus.miso   = loopback ? bus.mosi : slave_miso;
  assign bus_w.miso = miso_w;

  // Behavioural slave: samples mosi and presents its next preload bit on each rising sclk.
  logic [7:0] s_pre = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic [7:0] s_dout = 8'h00;
  bit         s_rdy = 1'b0;
  int         s_cnt = 0;
  always @(posedge bus.ss) begin
    s_cnt = 0;
    s_rdy = 1'b0;
  end
  always @(posedge bus.sclk) begin
    if (bus.ss && s_cnt < 8) begin
      s_rx = {s_rx[6:0], bus.mosi};
      slave_miso = s_pre[7 - s_cnt];
      s_cnt++;
      if (s_cnt == 8) begin
        s_rdy = 1'b1;
        s_dout = s_rx;
      end
    end
  end

  // Observations of the 8-bit instance, one entry per cycle starting at A+1.
  int         rise_q[$];
  bit         mosi_q[$];
  int         done_q[$];
  logic [7:0] dout_q[$];
  bit         ss_log[200];
  bit         busy_log[200];
  bit         mosi_log[200];

  task automatic start_xfer(input logic [7:0] d, output int a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = d;
    a = cyc;
  endtask

  task automatic capture(input int ncyc, input int hold_len, input int pulse_at,
                         input logic [7:0] pulse_data, input int chg_at,
                         input logic [7:0] chg_data);
    bit prev = 1'b0;
    rise_q.delete(); mosi_q.delete(); done_q.delete(); dout_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      ss_log[i] = bus.ss;
      busy_log[i] = bus.busy;
      mosi_log[i] = bus.mosi;
      if (bus.sclk && !prev) begin
        rise_q.push_back(cyc);
        mosi_q.push_back(bus.mosi);
      end
      prev = bus.sclk;
      if (bus.done) begin
        done_q.push_back(cyc);
        dout_q.push_back(bus.data_out);
      end
      bus.start = (i < hold_len) || (i == pulse_at);
      if (i == pulse_at) bus.data_in = pulse_data;
      if (i == chg_at) bus.data_in = chg_data;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.data_in = 8'h00;
    bus_w.start = 1'b0; bus_w.data_in = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sclk, bus.ss, bus.mosi} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_pins got busy,done,sclk,ss,mosi=%b expected 00000",
               {bus.busy, bus.done, bus.sclk, bus.ss, bus.mosi});
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data_out got %h expected 00", bus.data_out);
    end
    checks++;
    if ({bus_w.busy, bus_w.sclk, bus_w.ss, bus_w.mosi, bus_w.data_out} !== 20'h00000) begin
      failures++;
      $display("FAIL reset_wide got %h expected 00000",
               {bus_w.busy, bus_w.sclk, bus_w.ss, bus_w.mosi, bus_w.data_out});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    int a;
    bit ok;
    loopback = 1'b1;
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? 8'hA5 : 8'($urandom);
      start_xfer(d, a);
      capture(40, 0, -1, 8'h00, -1, 8'h00);
      checks++;
      if (!(ss_log[0] && busy_log[0])) begin
        failures++;
        $display("FAIL setup_entry got ss=%0b busy=%0b at A+1 expected 1 1", ss_log[0], busy_log[0]);
      end
      ok = (rise_q.size() == 8);
      for (int k = 0; k < 8 && ok; k++) if (rise_q[k] != a + 1 + (2 * k + 1) * 2) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rise_times got %0d edges first=%0d expected 8 edges first=%0d",
                 rise_q.size(), (rise_q.size() > 0) ? rise_q[0] - a : -1, 3);
      end
      ok = (mosi_q.size() == 8);
      for (int k = 0; k < 8 && ok; k++) if (mosi_q[k] != d[7 - k]) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL mosi_seq word=%h got %0d bits expected MSB-first %h", d, mosi_q.size(), d);
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != a + 35) begin
        failures++;
        $display("FAIL done_time got %0d pulses first=A+%0d expected 1 at A+35",
                 done_q.size(), (done_q.size() > 0) ? done_q[0] - a : -1);
      end
      checks++;
      if (dout_q.size() != 1 || dout_q[0] !== d) begin
        failures++;
        $display("FAIL loop_data got %h expected %h", (dout_q.size() > 0) ? dout_q[0] : 8'hxx, d);
      end
      checks++;
      if (busy_log[34] !== 1'b0 || busy_log[33] !== 1'b1) begin
        failures++;
        $display("FAIL busy_end got A+34=%0b A+35=%0b expected 1 0", busy_log[33], busy_log[34]);
      end
      checks++;
      if (mosi_log[33] !== d[0] || mosi_log[34] !== 1'b0) begin
        failures++;
        $display("FAIL mosi_tail got A+34=%0b A+35=%0b expected %0b 0", mosi_log[33], mosi_log[34], d[0]);
      end
    end
  endtask

  task automatic test_slave;
    logic [7:0] m, p, got;
    int a;
    loopback = 1'b0;
    for (int t = 0; t < 2; t++) begin
      m = (t == 0) ? 8'hC3 : 8'($urandom);
      p = (t == 0) ? 8'h3C : 8'($urandom);
      s_pre = p;
      start_xfer(m, a);
      capture(40, 0, -1, 8'h00, -1, 8'h00);
      got = (dout_q.size() > 0) ? dout_q[0] : 8'hxx;
      checks++;
      if (got !== p) begin
        failures++;
        $display("FAIL slave_to_master got %h expected %h", got, p);
      end
      checks++;
      if (!s_rdy || s_dout !== m) begin
        failures++;
        $display("FAIL master_to_slave got rdy=%0b data=%h expected rdy=1 data=%h", s_rdy, s_dout, m);
      end
    end
    loopback = 1'b1;
  endtask

  task automatic test_busy_ignore;
    logic [7:0] d;
    int a;
    bit ok;
    d = 8'($urandom_range(0, 254));
    start_xfer(d, a);
    capture(45, 0, 9, 8'hFF, -1, 8'h00);
    ok = (mosi_q.size() == 8);
    for (int k = 0; k < 8 && ok; k++) if (mosi_q[k] != d[7 - k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL busy_ignore_mosi got %0d bits expected original word %h", mosi_q.size(), d);
    end
    checks++;
    if (done_q.size() != 1 || dout_q[0] !== d) begin
      failures++;
      $display("FAIL busy_ignore_done got %0d pulses expected 1 with data %h", done_q.size(), d);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d1, d2, got2;
    int a;
    d1 = 8'($urandom);
    d2 = ~d1;
    start_xfer(d1, a);
    capture(75, 60, -1, 8'h00, 33, d2);
    checks++;
    if (done_q.size() != 2 || done_q[0] != a + 35 || done_q[1] != a + 70) begin
      failures++;
      $display("FAIL b2b_done got %0d pulses at A+%0d,A+%0d expected A+35,A+70", done_q.size(),
               (done_q.size() > 0) ? done_q[0] - a : -1, (done_q.size() > 1) ? done_q[1] - a : -1);
    end
    checks++;
    if (!(ss_log[33] && !ss_log[34] && ss_log[35])) begin
      failures++;
      $display("FAIL b2b_ss_gap got ss A+34..A+36=%0b%0b%0b expected 101", ss_log[33], ss_log[34], ss_log[35]);
    end
    got2 = (dout_q.size() > 1) ? dout_q[1] : 8'hxx;
    checks++;
    if (got2 !== d2) begin
      failures++;
      $display("FAIL b2b_second_data got %h expected %h", got2, d2);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int a;
    start_xfer(8'hFF, a);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (18) @(negedge clk);
    checks++;
    if (bus.sclk !== 1'b1 || bus.mosi !== 1'b1) begin
      failures++;
      $display("FAIL mid_precondition got sclk=%0b mosi=%0b at A+19 expected 1 1", bus.sclk, bus.mosi);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sclk, bus.ss, bus.mosi, bus.busy, bus.data_out} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset_async got sclk,ss,mosi,busy=%b data_out=%h expected 0000 00",
               {bus.sclk, bus.ss, bus.mosi, bus.busy}, bus.data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(40, 0, -1, 8'h00, -1, 8'h00);
    checks++;
    if (done_q.size() != 0 || rise_q.size() != 0) begin
      failures++;
      $display("FAIL mid_no_done got %0d done pulses %0d edges expected 0 0", done_q.size(), rise_q.size());
    end
    d = 8'($urandom);
    start_xfer(d, a);
    capture(40, 0, -1, 8'h00, -1, 8'h00);
    checks++;
    if (done_q.size() != 1 || done_q[0] != a + 35 || dout_q[0] !== d) begin
      failures++;
      $display("FAIL mid_recover got %0d pulses data=%h expected 1 at A+35 data=%h",
               done_q.size(), (dout_q.size() > 0) ? dout_q[0] : 8'hxx, d);
    end
  endtask

  task automatic test_wide;
    logic [15:0] d, dow, exp_d;
    int a, dw, ndone;
    int rw[$];
    bit prev, ok;
    for (int t = 0; t < 2; t++) begin
      miso_w = (t == 0);
      exp_d = (t == 0) ? 16'hFFFF : 16'h0000;
      d = (t == 0) ? 16'h8001 : 16'($urandom);
      @(negedge clk);
      bus_w.start = 1'b1;
      bus_w.data_in = d;
      a = cyc;
      rw.delete();
      dw = -1; ndone = 0; dow = 16'hxxxx; prev = 1'b0;
      for (int i = 0; i < 140; i++) begin
        @(negedge clk);
        bus_w.start = 1'b0;
        if (bus_w.sclk && !prev) rw.push_back(cyc);
        prev = bus_w.sclk;
        if (bus_w.done) begin
          dw = cyc; dow = bus_w.data_out; ndone++;
        end
      end
      ok = (rw.size() == 16);
      for (int k = 0; k < 16 && ok; k++) if (rw[k] != a + 1 + (2 * k + 1) * 4) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL wide_rise_times got %0d edges first=A+%0d expected 16 first=A+5",
                 rw.size(), (rw.size() > 0) ? rw[0] - a : -1);
      end
      checks++;
      if (ndone != 1 || dw != a + 133) begin
        failures++;
        $display("FAIL wide_done got %0d pulses at A+%0d expected 1 at A+133", ndone, dw - a);
      end
      checks++;
      if (dow !== exp_d) begin
        failures++;
        $display("FAIL wide_data got %h expected %h", dow, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
